qam_demod_ctrl: RTL and testbench
=================================

// Module: qam_demod_ctrl
// PURPOSE
//  Sequences the 4-QAM demodulator back end: waits for the moving-average filters to settle and
//  generates a symbol-rate decision strobe. It hunts for a preamble in the 2-bit decisions
//  (data_demod), then packs the following symbols into bytes for a frame of fixed length.
//  Bytes go out over a valid/ready interface to the downstream framer/UART.
// PARAMETERS
//  SPS          8      samples (clk cycles) per symbol; >=2
//  SAMPLE_PHASE 7      symbol-counter value at which data_demod is sampled; 0..SPS-1
//  SETTLE_CYC   16     cycles after enable before symbol timing starts (filter fill + pipeline)
//  FRAME_BYTES  16     payload bytes per frame after preamble; >=1
//  PREAMBLE     8'hE4  4-symbol preamble, first symbol in [7:6] (11,10,01,00)
// PORTS
//  clk         in   1  system clock, all logic posedge
//  rst         in   1  synchronous, active-high reset
//  en          in   1  run enable; low forces IDLE
//  data_demod  in   2  per-symbol decision from demodulator, {I,Q}
//  sym_strobe  out  1  1-cycle pulse on the cycle data_demod is sampled
//  out_data    out  8  packed payload byte, first symbol in [7:6]
//  out_valid   out  1  out_data valid; held until out_ready
//  out_ready   in   1  downstream accepts when out_valid&&out_ready
//  locked      out  1  high in COLLECT state
//  frame_done  out  1  1-cycle pulse when the last byte of a frame is loaded into out_data
//  overflow    out  1  sticky: byte completed while out_valid&&!out_ready
// BEHAVIOUR
//  Reset: state=IDLE, all counters 0, every output 0.
//  FSM: IDLE -(en)-> SETTLE -(settle cnt==SETTLE_CYC-1)-> HUNT -(preamble match)-> COLLECT
//       -(FRAME_BYTES-th byte complete)-> HUNT. en=0 in any state -> IDLE next cycle.
//  en low (IDLE entry): counters cleared, out_valid cleared, locked=0; overflow retained.
//  overflow clears only on rst or on the IDLE->SETTLE transition.
//  Symbol timer: runs in HUNT and COLLECT only; sym_cnt counts 0..SPS-1 and wraps.
//  Starts at 0 on the first HUNT cycle. sym_strobe=1 when sym_cnt==SAMPLE_PHASE.
//  sym_cnt is not reset on HUNT->COLLECT or COLLECT->HUNT (symbol phase is continuous).
//  Sampling: on sym_strobe, shift_reg<={shift_reg[5:0],data_demod} (8-bit, 4 symbols).
//  HUNT: match is tested on the next-value of shift_reg at the strobe cycle. Needs >=4 symbols
//   shifted since HUNT entry (sym_seen count saturates at 4); on match -> COLLECT, dibit_cnt=0.
//  COLLECT: each strobe increments dibit_cnt (0..3). The strobe with dibit_cnt==3 completes a
//   byte: the next-value of shift_reg is loaded into out_data and out_valid=1 on the following
//   cycle, byte_cnt++. If out_valid&&!out_ready on that completion cycle: byte dropped, out_data
//   unchanged, overflow<=1, byte still counts toward FRAME_BYTES.
//  Accept with completion in the same cycle counts as free (ready wins); no overflow.
//  Handshake: out_valid falls the cycle after out_valid&&out_ready unless a new byte loads.
//   out_data is stable while out_valid&&!out_ready.
//  frame_done: pulses with the load (or drop) of byte FRAME_BYTES-1. locked falls with it.
//   shift_reg and sym_seen are cleared on HUNT re-entry. A pending out_valid byte survives into HUNT.
//  Latency: data_demod sampled at strobe -> out_data visible 1 cycle later.
//  Widths: counters sized $clog2 of their max; compare exact, no arithmetic overflow paths.
// STRUCTURE
//  qam_pkg: state enum (IDLE,SETTLE,HUNT,COLLECT), default PREAMBLE, DIBIT_W=2.
//  Sub-module qam_sym_timer: sym_cnt, wrap, sym_strobe gen (inputs run; params SPS,SAMPLE_PHASE).
//  Top: FSM, shift register, dibit/byte counters, output register, flags.
// TESTING
//  1 rst held 3 cyc mid-COLLECT with out_valid=1 -> all outputs 0 next cycle, state IDLE.
//  2 en=1 at t0 -> no sym_strobe before t0+1+SETTLE_CYC; strobes then every SPS (8) cycles.
//  3 Feed symbols 00,11,10,01,00 then A5 (10,10,01,01), ready=1 -> locked after 5th symbol, out_data=8'hA5.
//  4 Full frame of 16 bytes 00..0F, ready=1 -> 16 handshakes in order, frame_done on 16th, back to HUNT.
//  5 ready=0 for 2 byte times -> first byte held stable, second dropped, overflow=1 and stays 1.
//  6 en low mid-frame then high -> IDLE, out_valid=0, overflow cleared on restart, SETTLE repeats.

Source files
------------

// File: rtl/qam_pkg.sv
// Shared types and constants for the 4-QAM demodulator back-end controller.
package qam_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    HUNT    = 2'd2,
    COLLECT = 2'd3
  } state_e;

  localparam int         DIBIT_W      = 2;
  localparam logic [7:0] PREAMBLE_DEF = 8'hE4;

  // Oldest symbol ends up in [7:6] once four symbols have been shifted in.
  function automatic logic [7:0] shift_in(input logic [7:0] sr,
                                          input logic [DIBIT_W-1:0] d);
    return {sr[7-DIBIT_W:0], d};
  endfunction

endpackage

// File: rtl/qam_sym_timer.sv
// Symbol-rate timer: free-running modulo-SPS counter while run is high,
// strobing once per symbol at the chosen sampling phase.
module qam_sym_timer #(
  parameter int SPS          = 8,
  parameter int SAMPLE_PHASE = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic sym_strobe
);

  localparam int            CW    = $clog2(SPS);
  localparam logic [CW-1:0] LAST  = CW'(SPS - 1);
  localparam logic [CW-1:0] PHASE = CW'(SAMPLE_PHASE);

  logic [CW-1:0] sym_cnt_q;

  // Holding the count at zero while stopped makes the first running cycle phase 0.
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      sym_cnt_q <= '0;
    end else if (sym_cnt_q == LAST) begin
      sym_cnt_q <= '0;
    end else begin
      sym_cnt_q <= sym_cnt_q + CW'(1);
    end
  end

  assign sym_strobe = run && (sym_cnt_q == PHASE);

endmodule

// File: rtl/qam_demod_ctrl.sv
// 4-QAM back-end sequencer: filter settle wait, preamble hunt on the dibit
// decisions, and packing of a fixed-length payload into bytes on valid/ready.
module qam_demod_ctrl
  import qam_pkg::*;
#(
  parameter int         SPS          = 8,
  parameter int         SAMPLE_PHASE = 7,
  parameter int         SETTLE_CYC   = 16,
  parameter int         FRAME_BYTES  = 16,
  parameter logic [7:0] PREAMBLE     = PREAMBLE_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [DIBIT_W-1:0] data_demod,
  output logic               sym_strobe,
  output logic [7:0]         out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               locked,
  output logic               frame_done,
  output logic               overflow
);

  localparam int            SW          = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int            BW          = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
  localparam logic [BW-1:0] BYTE_LAST   = BW'(FRAME_BYTES - 1);
  localparam logic [2:0]    SEEN_FULL   = 3'd4;

  state_e        state_q;
  logic [SW-1:0] settle_cnt_q;
  logic [1:0]    dibit_cnt_q;
  logic [BW-1:0] byte_cnt_q;
  logic [2:0]    seen_q;
  logic [2:0]    seen_d;
  logic [7:0]    sr_q;
  logic [7:0]    sr_d;
  logic [7:0]    out_data_q;
  logic          out_valid_q;
  logic          locked_q;
  logic          frame_done_q;
  logic          overflow_q;
  logic          run;
  logic          strobe;
  logic          preamble_hit;
  logic          byte_done;

  // Gating with en keeps the strobe from announcing a sample that will be discarded.
  assign run = en && ((state_q == HUNT) || (state_q == COLLECT));

  qam_sym_timer #(
    .SPS          (SPS),
    .SAMPLE_PHASE (SAMPLE_PHASE)
  ) u_sym_timer (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .sym_strobe (strobe)
  );

  assign sr_d         = shift_in(sr_q, data_demod);
  assign seen_d       = (seen_q == SEEN_FULL) ? SEEN_FULL : seen_q + 3'd1;
  assign preamble_hit = (seen_d == SEEN_FULL) && (sr_d == PREAMBLE);
  assign byte_done    = (dibit_cnt_q == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      settle_cnt_q <= '0;
      dibit_cnt_q  <= '0;
      byte_cnt_q   <= '0;
      seen_q       <= '0;
      sr_q         <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      locked_q     <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (!en) begin
        state_q      <= IDLE;
        settle_cnt_q <= '0;
        dibit_cnt_q  <= '0;
        byte_cnt_q   <= '0;
        seen_q       <= '0;
        sr_q         <= '0;
        out_valid_q  <= 1'b0;
        locked_q     <= 1'b0;
      end else begin
        if (out_valid_q && out_ready) begin
          out_valid_q <= 1'b0;
        end
        unique case (state_q)
          IDLE: begin
            state_q      <= SETTLE;
            settle_cnt_q <= '0;
            overflow_q   <= 1'b0;
          end
          SETTLE: begin
            if (settle_cnt_q == SETTLE_LAST) begin
              state_q      <= HUNT;
              settle_cnt_q <= '0;
              sr_q         <= '0;
              seen_q       <= '0;
            end else begin
              settle_cnt_q <= settle_cnt_q + SW'(1);
            end
          end
          HUNT: begin
            if (strobe) begin
              sr_q   <= sr_d;
              seen_q <= seen_d;
              if (preamble_hit) begin
                state_q     <= COLLECT;
                locked_q    <= 1'b1;
                dibit_cnt_q <= '0;
                byte_cnt_q  <= '0;
              end
            end
          end
          COLLECT: begin
            if (strobe) begin
              sr_q        <= sr_d;
              dibit_cnt_q <= dibit_cnt_q + 2'd1;
              if (byte_done) begin
                // A byte still waiting downstream wins; the new one is lost but counted.
                if (out_valid_q && !out_ready) begin
                  overflow_q <= 1'b1;
                end else begin
                  out_data_q  <= sr_d;
                  out_valid_q <= 1'b1;
                end
                if (byte_cnt_q == BYTE_LAST) begin
                  state_q      <= HUNT;
                  locked_q     <= 1'b0;
                  frame_done_q <= 1'b1;
                  byte_cnt_q   <= '0;
                  sr_q         <= '0;
                  seen_q       <= '0;
                end else begin
                  byte_cnt_q <= byte_cnt_q + BW'(1);
                end
              end
            end
          end
        endcase
      end
    end
  end

  assign sym_strobe = strobe;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign locked     = locked_q;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_qam_demod_ctrl.sv
// Scoreboard bench for qam_demod_ctrl: symbol-level reference model feeds an
// expected-byte queue; a negedge monitor checks every output each cycle.
module tb_qam_demod_ctrl;

  localparam int         SPS          = 8;
  localparam int         SAMPLE_PHASE = 7;
  localparam int         SETTLE_CYC   = 16;
  localparam int         FRAME_BYTES  = 16;
  localparam logic [7:0] PRE          = 8'hE4;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] data_demod;
  logic       sym_strobe;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       locked;
  logic       frame_done;
  logic       overflow;

  always #5 clk = ~clk;

  qam_demod_ctrl #(
    .SPS          (SPS),
    .SAMPLE_PHASE (SAMPLE_PHASE),
    .SETTLE_CYC   (SETTLE_CYC),
    .FRAME_BYTES  (FRAME_BYTES),
    .PREAMBLE     (PRE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .data_demod (data_demod),
    .sym_strobe (sym_strobe),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .locked     (locked),
    .frame_done (frame_done),
    .overflow   (overflow)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int hunt_start  = -1;
  int next_strobe = 0;
  bit mon_on   = 1'b0;
  bit lock_exp = 1'b0;
  bit fd_exp   = 1'b0;
  bit ovf_exp  = 1'b0;
  bit rr_mode  = 1'b0;
  logic [7:0] exp_q[$];

  // Reference model state: symbol window while hunting, symbols of current byte while collecting.
  bit         m_hunt = 1'b1;
  logic [1:0] m_win[$];
  logic [1:0] m_col[$];
  int         m_bytes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    fd_exp = 1'b0;
    if (rr_mode) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  always @(negedge clk) begin
    bit st_exp;
    if (mon_on) begin
      st_exp = (hunt_start >= 0) && (cyc >= hunt_start) &&
               (((cyc - hunt_start) % SPS) == SAMPLE_PHASE);
      chk("sym_strobe", sym_strobe, st_exp);
      chk("out_valid", out_valid, exp_q.size() > 0);
      if (out_valid && exp_q.size() > 0) begin
        chk("out_data", out_data, exp_q[0]);
        if (out_ready) void'(exp_q.pop_front());
      end
      chk("locked", locked, lock_exp);
      chk("frame_done", frame_done, fd_exp);
      chk("overflow", overflow, ovf_exp);
    end
  end

  task automatic start();
    en = 1'b1;
    hunt_start  = cyc + 1 + SETTLE_CYC;
    next_strobe = hunt_start + SAMPLE_PHASE;
    m_hunt = 1'b1;
    m_win.delete();
    m_col.delete();
    m_bytes = 0;
    tick();
    ovf_exp = 1'b0;
  endtask

  task automatic stop();
    en = 1'b0;
    hunt_start = -1;
    tick();
    lock_exp = 1'b0;
    exp_q.delete();
  endtask

  task automatic feed(input logic [1:0] sym);
    bit         complete = 1'b0;
    bit         fend     = 1'b0;
    bit         drop;
    logic [7:0] b = '0;
    while (cyc < next_strobe) tick();
    data_demod = sym;
    if (m_hunt) begin
      m_win.push_back(sym);
      if (m_win.size() > 4) void'(m_win.pop_front());
      if (m_win.size() == 4 && {m_win[0], m_win[1], m_win[2], m_win[3]} == PRE) begin
        m_hunt = 1'b0;
        m_col.delete();
        m_bytes = 0;
      end
    end else begin
      m_col.push_back(sym);
      if (m_col.size() == 4) begin
        complete = 1'b1;
        b = {m_col[0], m_col[1], m_col[2], m_col[3]};
        m_col.delete();
        m_bytes++;
        if (m_bytes == FRAME_BYTES) begin
          fend   = 1'b1;
          m_hunt = 1'b1;
          m_win.delete();
        end
      end
    end
    drop = complete && (exp_q.size() > 0) && !out_ready;
    tick();
    data_demod = 2'($urandom);
    if (complete) begin
      if (drop) ovf_exp = 1'b1;
      else      exp_q.push_back(b);
    end
    fd_exp   = fend;
    lock_exp = !m_hunt;
    next_strobe += SPS;
  endtask

  task automatic send_byte(input logic [7:0] b);
    feed(b[7:6]);
    feed(b[5:4]);
    feed(b[3:2]);
    feed(b[1:0]);
  endtask

  task automatic do_reset(input int ncyc);
    rst = 1'b1;
    tick();
    hunt_start = -1;
    lock_exp = 1'b0;
    fd_exp   = 1'b0;
    ovf_exp  = 1'b0;
    exp_q.delete();
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_locked", locked, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_sym_strobe", sym_strobe, 1'b0);
    repeat (ncyc - 1) tick();
    rst = 1'b0;
    en  = 1'b0;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    en = 1'b0;
    out_ready = 1'b1;
    data_demod = 2'b00;
    tick();
    mon_on = 1'b1;
    tick();
    tick();
    chk("init_out_data", out_data, 8'h00);
    chk("init_out_valid", out_valid, 1'b0);
    rst = 1'b0;
    tick();

    // Settle timing, preamble lock after fifth symbol, first payload byte.
    start();
    feed(2'b00);
    send_byte(PRE);
    chk("locked_after_preamble", locked, 1'b1);
    send_byte(8'hA5);
    chk("first_byte", out_data, 8'hA5);
    repeat (FRAME_BYTES - 1) send_byte(8'($urandom));
    chk("unlocked_after_frame", locked, 1'b0);

    // Frame of ascending bytes.
    repeat (3) feed(2'($urandom));
    send_byte(PRE);
    for (int i = 0; i < FRAME_BYTES; i++) send_byte(8'(i));

    // Random garbage, preambles, payloads and downstream stalls.
    rr_mode = 1'b1;
    repeat (3) begin
      repeat ($urandom_range(0, 5)) feed(2'($urandom));
      send_byte(PRE);
      repeat (FRAME_BYTES) send_byte(8'($urandom));
    end
    rr_mode = 1'b0;
    out_ready = 1'b1;

    // Stall for two byte times: first held, second dropped.
    stop();
    repeat (3) tick();
    start();
    send_byte(PRE);
    out_ready = 1'b0;
    send_byte(8'h3C);
    send_byte(8'hC3);
    chk("overflow_set", overflow, 1'b1);
    chk("held_byte", out_data, 8'h3C);
    out_ready = 1'b1;
    repeat (FRAME_BYTES - 2) send_byte(8'($urandom));
    chk("overflow_sticky", overflow, 1'b1);

    // Drop enable mid-frame, then restart.
    send_byte(PRE);
    repeat (3) send_byte(8'($urandom));
    stop();
    chk("stop_out_valid", out_valid, 1'b0);
    chk("stop_locked", locked, 1'b0);
    repeat (5) tick();
    chk("overflow_kept_idle", overflow, 1'b1);
    start();
    chk("overflow_cleared_restart", overflow, 1'b0);
    feed(2'b01);
    send_byte(PRE);
    send_byte(8'h96);
    send_byte(8'h69);

    // Reset mid-collect with a byte pending.
    out_ready = 1'b0;
    send_byte(8'h5A);
    feed(2'b01);
    feed(2'b10);
    do_reset(3);
    out_ready = 1'b1;
    start();
    feed(2'b00);
    send_byte(PRE);
    send_byte(8'h81);
    repeat (4) tick();
    chk("scoreboard_drained", exp_q.size(), 0);

    mon_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
